pc_stack: RTL

Program-counter stage built on the clocked bit/register primitives: a Hack-style PC (reset/load/inc) extended with a hardware return-address stack for call/return. Sits directly downstream of the D flip-flop and register layer. It consumes registered state and produces the instruction address driven into instruction memory each cycle. All state changes on the rising clock edge, except reset, which is asynchronous.

---
 rtl/pc_stack_pkg.sv | 36 +++
 rtl/pc_stack_return_stack.sv | 60 ++++++
 rtl/pc_stack.sv | 88 ++++++++
 3 files changed

// File: rtl/pc_stack_pkg.sv
// ============================================================================
// Module  : pc_stack_pkg
// Brief   : Shared defaults and command decode for the PC / return-stack stage
// Revision: 1.0
// ============================================================================
`default_nettype none

package pc_stack_pkg;

  localparam int DEF_WIDTH  = 16;
  localparam int DEF_DEPTH  = 8;
  localparam int DEPTH_BITS = $clog2(DEF_DEPTH + 1);

  typedef enum logic [2:0] {
    CMD_HOLD = 3'd0,
    CMD_INC  = 3'd1,
    CMD_LOAD = 3'd2,
    CMD_RET  = 3'd3,
    CMD_CALL = 3'd4,
    CMD_TAIL = 3'd5
  } cmd_t;

  // First match wins: call&ret, call, ret, load, inc, hold.
  function automatic cmd_t decode_cmd(input logic call, input logic ret,
                                      input logic load, input logic inc);
    if (call && ret) return CMD_TAIL;
    if (call)        return CMD_CALL;
    if (ret)         return CMD_RET;
    if (load)        return CMD_LOAD;
    if (inc)         return CMD_INC;
    return CMD_HOLD;
  endfunction

endpackage

`default_nettype wire

// File: rtl/pc_stack_return_stack.sv
// ============================================================================
// Module  : return_stack
// Brief   : LIFO of return addresses indexed by an occupancy counter
// Revision: 1.0
// ============================================================================
`default_nettype none

module return_stack
  import pc_stack_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int DEPTH = DEF_DEPTH
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       push,
  input  logic                       pop,
  input  logic [WIDTH-1:0]           push_data,
  output logic [WIDTH-1:0]           top,
  output logic [$clog2(DEPTH+1)-1:0] depth,
  output logic                       full,
  output logic                       empty
);

  localparam int c_DB = $clog2(DEPTH + 1);
  localparam int c_IB = $clog2(DEPTH);
  localparam logic [c_DB-1:0] c_ONE  = c_DB'(1);
  localparam logic [c_DB-1:0] c_FULL = c_DB'(DEPTH);

  logic [WIDTH-1:0] r_stack [DEPTH];
  logic [c_DB-1:0]  r_depth;
  logic [c_DB-1:0]  w_top_pos;
  logic [c_IB-1:0]  w_top_idx;
  logic [c_IB-1:0]  w_push_idx;

  // With depth==0 the index wraps to a valid slot; the caller never uses it.
  assign w_top_pos  = r_depth - c_ONE;
  assign w_top_idx  = w_top_pos[c_IB-1:0];
  assign w_push_idx = r_depth[c_IB-1:0];

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_depth <= '0;
      for (int i = 0; i < DEPTH; i++) r_stack[i] <= '0;
    end else if (push) begin
      r_stack[w_push_idx] <= push_data;
      r_depth             <= r_depth + c_ONE;
    end else if (pop) begin
      r_depth <= w_top_pos;
    end
  end

  assign top   = r_stack[w_top_idx];
  assign depth = r_depth;
  assign full  = (r_depth == c_FULL);
  assign empty = (r_depth == '0);

endmodule

`default_nettype wire

// File: rtl/pc_stack.sv
// ============================================================================
// Module  : pc_stack
// Brief   : Program counter with load/inc and a hardware call/return stack
// Revision: 1.0
// ============================================================================
`default_nettype none

module pc_stack
  import pc_stack_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int DEPTH = DEF_DEPTH
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic [WIDTH-1:0]           in,
  input  logic                       load,
  input  logic                       inc,
  input  logic                       call,
  input  logic                       ret,
  output logic [WIDTH-1:0]           out,
  output logic [$clog2(DEPTH+1)-1:0] depth,
  output logic                       empty,
  output logic                       full,
  output logic                       error
);

  cmd_t             w_cmd;
  logic [WIDTH-1:0] w_next_pc;
  logic [WIDTH-1:0] w_top;
  logic             w_full;
  logic             w_empty;
  logic             w_push;
  logic             w_pop;
  logic [WIDTH-1:0] r_out;
  logic             r_error;

  assign w_cmd     = decode_cmd(call, ret, load, inc);
  assign w_next_pc = r_out + WIDTH'(1);
  // Overflow/underflow never reach the stack; they only raise the error flag.
  assign w_push    = (w_cmd == CMD_CALL) && !w_full;
  assign w_pop     = (w_cmd == CMD_RET)  && !w_empty;

  return_stack #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) u_return_stack (
    .clock     (clock),
    .reset     (reset),
    .push      (w_push),
    .pop       (w_pop),
    .push_data (w_next_pc),
    .top       (w_top),
    .depth     (depth),
    .full      (w_full),
    .empty     (w_empty)
  );

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_out   <= '0;
      r_error <= 1'b0;
    end else begin
      case (w_cmd)
        CMD_TAIL: r_out <= in;
        CMD_CALL: begin
          if (w_full) r_error <= 1'b1;
          else        r_out   <= in;
        end
        CMD_RET: begin
          if (w_empty) r_error <= 1'b1;
          else         r_out   <= w_top;
        end
        CMD_LOAD: r_out <= in;
        CMD_INC:  r_out <= w_next_pc;
        default:  r_out <= r_out;
      endcase
    end
  end

  assign out   = r_out;
  assign error = r_error;
  assign full  = w_full;
  assign empty = w_empty;

endmodule

`default_nettype wire
